// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern source.
// Holds mode encodings, the colour-bar table and default 640x480 timing.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Per-channel on/off mask {R,G,B} for each of the eight bars.
    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        logic [2:0] m;
        m = 3'b000;
        case (idx)
            3'd0:    m = 3'b111;
            3'd1:    m = 3'b110;
            3'd2:    m = 3'b011;
            3'd3:    m = 3'b010;
            3'd4:    m = 3'b101;
            3'd5:    m = 3'b100;
            3'd6:    m = 3'b001;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // Bar colour expanded to full channel width: each channel all-ones or zero.
    function automatic logic [47:0] bar_color(input logic [2:0] idx,
                                              input int cb);
        logic [2:0]  m;
        logic [47:0] c;
        m = bar_mask(idx);
        c = '0;
        for (int i = 0; i < cb; i++) begin
            c[i]        = m[0];
            c[cb + i]   = m[1];
            c[2*cb + i] = m[2];
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_core.sv
// Horizontal/vertical pixel counters with region decode.
// Ports: clk, reset, pix_en in; hc, vc, active/sync flags, line/frame end out.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic [XW-1:0] hc,
    output logic [YW-1:0] vc,
    output logic          h_act,
    output logic          v_act,
    output logic          hs_act,
    output logic          vs_act,
    output logic          line_end,
    output logic          frame_end
);

    localparam int HS_LO = H_ACTIVE + H_FP;
    localparam int HS_HI = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_LO = V_ACTIVE + V_FP;
    localparam int VS_HI = V_ACTIVE + V_FP + V_SYNC;

    always_comb begin
        line_end  = (int'(hc) == H_TOTAL - 1);
        frame_end = line_end && (int'(vc) == V_TOTAL - 1);
        h_act     = (int'(hc) < H_ACTIVE);
        v_act     = (int'(vc) < V_ACTIVE);
        hs_act    = (int'(hc) >= HS_LO) && (int'(hc) < HS_HI);
        vs_act    = (int'(vc) >= VS_LO) && (int'(vc) < VS_HI);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_en) begin
            if (line_end) begin
                hc <= '0;
                vc <= frame_end ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: solid, bars, checker, gradient, frame-synchronous.
// Ports: clk, reset, pix_en, mode, color in; rgb, h_sync, v_sync, video_on, frame_start out.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int COLOR_BITS = 4,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pix_en,
    input  logic [1:0]              mode,
    input  logic [3*COLOR_BITS-1:0] color,
    output logic [3*COLOR_BITS-1:0] rgb,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic                    video_on,
    output logic                    frame_start
);

    localparam int RGB_W   = 3 * COLOR_BITS;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int LX      = $clog2(H_ACTIVE);

    logic [XW-1:0]    hc;
    logic [YW-1:0]    vc;
    logic             h_act;
    logic             v_act;
    logic             hs_act;
    logic             vs_act;
    logic             line_end;
    logic             frame_end;

    mode_t            mode_q;
    logic [RGB_W-1:0] color_q;
    logic [BW-1:0]    bar_cnt;
    logic [2:0]       bar_idx;

    logic [2:0]            bmask;
    logic [COLOR_BITS-1:0] lvl;
    logic [RGB_W-1:0]      pix;
    logic                  active;

    vga_timing_core #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .hc        (hc),
        .vc        (vc),
        .h_act     (h_act),
        .v_act     (v_act),
        .hs_act    (hs_act),
        .vs_act    (vs_act),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    always_comb begin
        active = h_act && v_act;
        bmask  = bar_mask(bar_idx);
        lvl    = hc[LX-1 -: COLOR_BITS];
        pix    = '0;
        unique case (mode_q)
            MODE_SOLID: pix = color_q;
            MODE_BARS: begin
                for (int ch = 0; ch < 3; ch++)
                    pix[ch*COLOR_BITS +: COLOR_BITS] = {COLOR_BITS{bmask[ch]}};
            end
            MODE_CHECK: begin
                if (hc[CHECK_LOG2] ^ vc[CHECK_LOG2])
                    pix = color_q;
            end
            MODE_GRAD: begin
                for (int ch = 0; ch < 3; ch++)
                    pix[ch*COLOR_BITS +: COLOR_BITS] =
                        (|color_q[ch*COLOR_BITS +: COLOR_BITS]) ? lvl : '0;
            end
            default: pix = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= MODE_SOLID;
            color_q     <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            rgb         <= '0;
            h_sync      <= ~SYNC_POL;
            v_sync      <= ~SYNC_POL;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // frame_start is a single-clk strobe, cleared even on idle clks
            frame_start <= 1'b0;
            if (pix_en) begin
                rgb         <= active ? pix : '0;
                h_sync      <= hs_act ? SYNC_POL : ~SYNC_POL;
                v_sync      <= vs_act ? SYNC_POL : ~SYNC_POL;
                video_on    <= active;
                frame_start <= (hc == '0) && (vc == '0);
                if (frame_end) begin
                    mode_q  <= mode_t'(mode);
                    color_q <= color;
                end
                // bar_idx tracks hc / BAR_W without a divider
                if (line_end) begin
                    bar_cnt <= '0;
                    bar_idx <= '0;
                end else if (h_act) begin
                    if (int'(bar_cnt) == BAR_W - 1) begin
                        bar_cnt <= '0;
                        bar_idx <= bar_idx + 1'b1;
                    end else begin
                        bar_cnt <= bar_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised bench for vga_pattern_gen against a pixel-level reference model.
// Uses a reduced 80x19 raster so many frames fit in a short run.
module tb_vga_pattern_gen;

    localparam int CB  = 4;
    localparam int HA  = 64;
    localparam int HFP = 4;
    localparam int HS  = 8;
    localparam int HBP = 4;
    localparam int VA  = 12;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int CL  = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic        clk;
    logic        reset;
    logic        pix_en;
    logic [1:0]  mode;
    logic [11:0] color;
    logic [11:0] rgb;
    logic        h_sync;
    logic        v_sync;
    logic        video_on;
    logic        frame_start;

    int total;
    int bad;
    int cyc;
    bit rnd_in;

    int          mx;
    int          my;
    int          smode;
    logic [11:0] scol;
    logic [11:0] e_rgb;
    logic        e_hs;
    logic        e_vs;
    logic        e_von;
    logic        e_fs;

    vga_pattern_gen #(
        .COLOR_BITS (CB),
        .H_ACTIVE   (HA),
        .H_FP       (HFP),
        .H_SYNC     (HS),
        .H_BP       (HBP),
        .V_ACTIVE   (VA),
        .V_FP       (VFP),
        .V_SYNC     (VS),
        .V_BP       (VBP),
        .SYNC_POL   (1'b0),
        .CHECK_LOG2 (CL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .mode        (mode),
        .color       (color),
        .rgb         (rgb),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .video_on    (video_on),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Pixel colour from the pattern rules, using plain arithmetic on x, y.
    function automatic logic [11:0] ref_pix(input int x, input int y,
                                            input int m, input logic [11:0] c);
        int bars[8];
        int k;
        int lv;
        logic [11:0] p;
        bars = '{7, 6, 3, 2, 5, 4, 1, 0};
        p = '0;
        if (x >= HA || y >= VA) return 12'h000;
        case (m)
            0: p = c;
            1: begin
                k = bars[x / (HA / 8)];
                for (int ch = 0; ch < 3; ch++)
                    if (((k >> ch) & 1) != 0) p = p | (12'hF << (4 * ch));
            end
            2: p = ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? c : 12'h000;
            default: begin
                lv = (x >> ($clog2(HA) - CB)) % 16;
                for (int ch = 0; ch < 3; ch++)
                    if (((c >> (4 * ch)) & 12'hF) != 0)
                        p = p | 12'(lv << (4 * ch));
            end
        endcase
        return p;
    endfunction

    task automatic model_reset();
        mx = 0;
        my = 0;
        smode = 0;
        scol = '0;
        e_rgb = '0;
        e_hs = 1'b1;
        e_vs = 1'b1;
        e_von = 1'b0;
        e_fs = 1'b0;
    endtask

    task automatic compare_all(input string ph);
        chk({ph, ".rgb"}, 32'(rgb), 32'(e_rgb));
        chk({ph, ".h_sync"}, 32'(h_sync), 32'(e_hs));
        chk({ph, ".v_sync"}, 32'(v_sync), 32'(e_vs));
        chk({ph, ".video_on"}, 32'(video_on), 32'(e_von));
        chk({ph, ".frame_start"}, 32'(frame_start), 32'(e_fs));
    endtask

    task automatic step(input bit pe);
        @(negedge clk);
        pix_en = pe;
        if (rnd_in && $urandom_range(0, 299) == 0) begin
            mode = 2'($urandom_range(0, 3));
            color = 12'($urandom);
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            e_fs = 1'b0;
            if (pe) begin
                e_rgb = ref_pix(mx, my, smode, scol);
                e_von = (mx < HA) && (my < VA);
                e_hs = !(mx >= HA + HFP && mx < HA + HFP + HS);
                e_vs = !(my >= VA + VFP && my < VA + VFP + VS);
                e_fs = (mx == 0) && (my == 0);
                if (mx == HT - 1 && my == VT - 1) begin
                    smode = int'(mode);
                    scol = color;
                end
                mx++;
                if (mx == HT) begin
                    mx = 0;
                    my = (my + 1) % VT;
                end
            end
        end
        cyc++;
        #1;
        compare_all("px");
    endtask

    // pm: 0 = pix_en always, 1 = random 3 in 4, 2 = every fourth clk
    task automatic run_pix(input int n, input int pm);
        int done;
        bit pe;
        done = 0;
        while (done < n) begin
            case (pm)
                0: pe = 1'b1;
                1: pe = ($urandom_range(0, 3) != 0);
                default: pe = (cyc % 4 == 0);
            endcase
            step(pe);
            if (pe) done++;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        rnd_in = 1'b0;
        pix_en = 1'b0;
        mode = 2'd0;
        color = 12'hF80;
        model_reset();
        reset = 1'b1;
        #12;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // frame 0 black, F80 solid latched for frame 1
        run_pix(FRAME, 0);
        run_pix(10, 0);
        mode = 2'd1;
        color = 12'h123;
        run_pix(FRAME - 10, 0);
        run_pix(10, 1);
        mode = 2'd2;
        color = 12'h0F0;
        run_pix(FRAME - 10, 1);
        run_pix(10, 1);
        mode = 2'd3;
        color = 12'hF00;
        run_pix(FRAME - 10, 1);
        run_pix(FRAME, 1);

        rnd_in = 1'b1;
        run_pix(4 * FRAME, 1);
        rnd_in = 1'b0;

        // mid-frame switch, then asynchronous reset with sparse pix_en
        mode = 2'd0;
        color = 12'hABC;
        run_pix(FRAME - mx - my * HT, 2);
        run_pix(2 * HT, 2);
        mode = 2'd1;
        run_pix(2 * HT, 2);
        @(negedge clk);
        pix_en = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        step(1'b1);
        step(1'b0);
        reset = 1'b0;
        run_pix(2 * FRAME, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
